// File: rtl/alu_pkg.sv
// Shared types and constants for the multi-cycle execution ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    ADD  = 4'd0,
    SUB  = 4'd1,
    AND  = 4'd2,
    OR   = 4'd3,
    XOR  = 4'd4,
    SLL  = 4'd5,
    SRL  = 4'd6,
    SRA  = 4'd7,
    SLT  = 4'd8,
    SLTU = 4'd9,
    MUL  = 4'd10
  } alu_op_e;

  // State names carry an S_ prefix so they cannot collide with the MUL opcode.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } alu_state_e;

  localparam int FLG_V = 0;
  localparam int FLG_C = 1;
  localparam int FLG_N = 2;
  localparam int FLG_Z = 3;

endpackage

// File: rtl/alu_mc_if.sv
// Issue-side and writeback-side handshake bundle of the execution ALU.
interface alu_mc_if #(parameter int WIDTH = 64);
  import alu_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  alu_op_e          ALUOp;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] ALUResult;
  logic [3:0]       ALUFlags;

  modport master (
    output in_valid, SrcA, SrcB, ALUOp, out_ready,
    input  in_ready, out_valid, ALUResult, ALUFlags
  );

  modport slave (
    input  in_valid, SrcA, SrcB, ALUOp, out_ready,
    output in_ready, out_valid, ALUResult, ALUFlags
  );

endinterface

// File: rtl/alu_mc_mul_iter.sv
// Iterative shift-add multiplier retiring MUL_STEP multiplier bits per cycle.
// The first partial product is folded in on the start edge, so the product is
// complete WIDTH/MUL_STEP edges after start, counting the start edge.
module alu_mul_iter #(
  parameter int WIDTH    = 64,
  parameter int MUL_STEP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int ITERS = WIDTH / MUL_STEP;
  localparam int CW    = $clog2(ITERS + 1);
  localparam logic [CW-1:0] ITERS_C = CW'(ITERS);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] cur_mcand;
  logic [WIDTH-1:0] cur_mplier;
  logic [WIDTH-1:0] pp;

  assign done    = busy && (count == ITERS_C);
  assign product = acc;

  // Partial product of the current multiplicand and the low MUL_STEP multiplier bits.
  always_comb begin
    cur_mcand  = start ? a : mcand;
    cur_mplier = start ? b : mplier;
    pp = '0;
    for (int i = 0; i < MUL_STEP; i++) begin
      if (cur_mplier[i]) pp = pp + (cur_mcand << i);
    end
  end

  // Shift registers, accumulator and iteration counter; reset aborts any product.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      count  <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      count  <= CW'(1);
      acc    <= pp;
      mcand  <= a << MUL_STEP;
      mplier <= b >> MUL_STEP;
    end else if (done) begin
      busy <= 1'b0;
    end else if (busy) begin
      count  <= count + 1'b1;
      acc    <= acc + pp;
      mcand  <= mcand << MUL_STEP;
      mplier <= mplier >> MUL_STEP;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle execution ALU: single-cycle ops finish on the accepting edge,
// MUL runs through the iterative multiplier; results and flags are registered.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH    = 64,
  parameter int MUL_STEP = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_mc_if.slave  bus
);

  localparam int SHW = $clog2(WIDTH);

  alu_state_e       state;
  alu_state_e       next_state;
  logic             in_ready_c;
  logic             out_valid_c;
  logic             accept;
  logic             mul_start;
  logic             mul_busy;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] res_d;
  logic [3:0]       flags_d;
  logic             v_d;
  logic             c_d;
  logic             undef;
  logic [WIDTH-1:0] result_q;
  logic [3:0]       flags_q;

  assign accept       = bus.in_valid && in_ready_c;
  assign mul_start    = accept && (bus.ALUOp == MUL);
  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.ALUResult = result_q;
  assign bus.ALUFlags  = flags_q;

  alu_mul_iter #(.WIDTH(WIDTH), .MUL_STEP(MUL_STEP)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (bus.SrcA),
    .b       (bus.SrcB),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    next_state  = state;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready_c = !mul_busy;
        if (bus.in_valid && !mul_busy)
          next_state = (bus.ALUOp == MUL) ? S_MUL : S_DONE;
      end
      S_MUL: begin
        if (mul_done) next_state = S_DONE;
      end
      S_DONE: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Single-cycle datapath on the live operands, captured on the accepting edge.
  always_comb begin
    b_eff = (bus.ALUOp == SUB) ? ~bus.SrcB : bus.SrcB;
    sum   = {1'b0, bus.SrcA} + {1'b0, b_eff} + (WIDTH+1)'(bus.ALUOp == SUB);
    shamt = bus.SrcB[SHW-1:0];
    res_d = '0;
    v_d   = 1'b0;
    c_d   = 1'b0;
    undef = 1'b0;
    case (bus.ALUOp)
      ADD, SUB: begin
        res_d = sum[WIDTH-1:0];
        c_d   = sum[WIDTH];
        v_d   = (bus.SrcA[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != bus.SrcA[WIDTH-1]);
      end
      AND:  res_d = bus.SrcA & bus.SrcB;
      OR:   res_d = bus.SrcA | bus.SrcB;
      XOR:  res_d = bus.SrcA ^ bus.SrcB;
      SLL:  res_d = bus.SrcA << shamt;
      SRL:  res_d = bus.SrcA >> shamt;
      SRA:  res_d = WIDTH'($signed(bus.SrcA) >>> shamt);
      SLT:  res_d = WIDTH'($signed(bus.SrcA) < $signed(bus.SrcB));
      SLTU: res_d = WIDTH'(bus.SrcA < bus.SrcB);
      MUL:  res_d = '0;
      default: undef = 1'b1;
    endcase
    flags_d        = 4'b0000;
    flags_d[FLG_V] = v_d;
    flags_d[FLG_C] = c_d;
    flags_d[FLG_N] = res_d[WIDTH-1];
    flags_d[FLG_Z] = (res_d == '0);
    if (undef) flags_d = 4'b0001;
  end

  // Result/flag registers: load on a single-cycle accept or on multiplier completion, hold otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_q <= '0;
      flags_q  <= '0;
    end else if (accept && (bus.ALUOp != MUL)) begin
      result_q <= res_d;
      flags_q  <= flags_d;
    end else if ((state == S_MUL) && mul_done) begin
      result_q <= mul_product;
      flags_q  <= {(mul_product == '0), mul_product[WIDTH-1], 2'b00};
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc with WIDTH=64, MUL_STEP=4.
module tb_alu_mc;
  import alu_pkg::*;

  logic clk;
  logic rst_n;
  int   total_checks = 0;
  int   bad_checks   = 0;
  int   lat;
  int   no_ready;

  alu_mc_if #(.WIDTH(64)) bus ();

  alu_mc #(.WIDTH(64), .MUL_STEP(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total_checks++;
    if (observed !== expected) begin
      bad_checks++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one bundle, then count edges (accepting edge included) until out_valid.
  task automatic applyStimulus(input alu_op_e op, input logic [63:0] a, input logic [63:0] b,
                               output int latency, output int busy_cycles);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.ALUOp    = op;
    bus.SrcA     = a;
    bus.SrcB     = b;
    @(posedge clk);
    latency     = 1;
    busy_cycles = 0;
    #1;
    bus.in_valid = 1'b0;
    bus.SrcA     = 64'hDEAD_BEEF_0BAD_F00D;
    bus.SrcB     = 64'h1234_5678_9ABC_DEF0;
    bus.ALUOp    = ADD;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!bus.in_ready) busy_cycles++;
      if (bus.out_valid) break;
      @(posedge clk);
      latency++;
    end
    if (!bus.out_valid) checkOutput("timeout_out_valid", 64'(bus.out_valid), 64'd1);
  endtask

  // Handshake the result away and confirm the block is back in IDLE.
  task automatic consumeResult(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    checkOutput({tag, "_idle_ready"}, 64'(bus.in_ready), 64'd1);
    checkOutput({tag, "_idle_nvalid"}, 64'(bus.out_valid), 64'd0);
  endtask

  task automatic runOp(input string tag, input alu_op_e op, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp_res, input logic [3:0] exp_flags, input int exp_lat);
    int l;
    int nr;
    applyStimulus(op, a, b, l, nr);
    checkOutput({tag, "_res"}, bus.ALUResult, exp_res);
    checkOutput({tag, "_flags"}, 64'(bus.ALUFlags), 64'(exp_flags));
    checkOutput({tag, "_lat"}, 64'(l), 64'(exp_lat));
    consumeResult(tag);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.SrcA      = '0;
    bus.SrcB      = '0;
    bus.ALUOp     = ADD;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_in_ready", 64'(bus.in_ready), 64'd1);
    checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("rst_result", bus.ALUResult, 64'd0);
    checkOutput("rst_flags", 64'(bus.ALUFlags), 64'd0);

    runOp("add_ovf", ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 4'b0101, 1);
    runOp("sub_eq", SUB, 64'd5, 64'd5, 64'd0, 4'b1010, 1);
    runOp("sub_borrow", SUB, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0100, 1);
    runOp("and", AND, 64'h0F0F_0F0F_0F0F_0F0F, 64'h00FF_00FF_00FF_00FF, 64'h000F_000F_000F_000F, 4'b0000, 1);
    runOp("or", OR, 64'h0F0F_0F0F_0F0F_0F0F, 64'h00FF_00FF_00FF_00FF, 64'h0FFF_0FFF_0FFF_0FFF, 4'b0000, 1);
    runOp("xor", XOR, 64'h0F0F_0F0F_0F0F_0F0F, 64'h00FF_00FF_00FF_00FF, 64'h0FF0_0FF0_0FF0_0FF0, 4'b0000, 1);
    runOp("sll", SLL, 64'd1, 64'd63, 64'h8000_0000_0000_0000, 4'b0100, 1);
    runOp("srl", SRL, 64'h8000_0000_0000_0000, 64'h43, 64'h1000_0000_0000_0000, 4'b0000, 1);
    runOp("sra", SRA, 64'h8000_0000_0000_0000, 64'h43, 64'hF000_0000_0000_0000, 4'b0100, 1);
    runOp("sltu", SLTU, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b0000, 1);
    runOp("slt", SLT, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 4'b1000, 1);
    runOp("undef", alu_op_e'(4'd13), 64'd7, 64'd9, 64'd0, 4'b0001, 1);
    runOp("mul_small", MUL, 64'd6, 64'd7, 64'd42, 4'b0000, 17);

    // MUL with the in_ready low-time check
    applyStimulus(MUL, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, lat, no_ready);
    checkOutput("mul_res", bus.ALUResult, 64'hFFFF_FFFF_FFFF_FFFD);
    checkOutput("mul_flags", 64'(bus.ALUFlags), 64'b0100);
    checkOutput("mul_lat", 64'(lat), 64'd17);
    checkOutput("mul_not_ready", 64'(no_ready), 64'd17);
    consumeResult("mul");

    // Back-pressure: result held while a competing bundle is offered
    applyStimulus(ADD, 64'h10, 64'h20, lat, no_ready);
    bus.in_valid = 1'b1;
    bus.ALUOp    = SUB;
    bus.SrcA     = 64'd1;
    bus.SrcB     = 64'd2;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("hold_res", bus.ALUResult, 64'h30);
      checkOutput("hold_flags", 64'(bus.ALUFlags), 64'd0);
      checkOutput("hold_ready", 64'(bus.in_ready), 64'd0);
      checkOutput("hold_valid", 64'(bus.out_valid), 64'd1);
    end
    bus.in_valid = 1'b0;
    consumeResult("hold");

    // Reset in the middle of a MUL
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.ALUOp    = MUL;
    bus.SrcA     = 64'hFFFF_FFFF_FFFF_FFFF;
    bus.SrcB     = 64'd3;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_mul_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("rst_mul_result", bus.ALUResult, 64'd0);
    checkOutput("rst_mul_ready", 64'(bus.in_ready), 64'd1);
    runOp("add_after_rst", ADD, 64'd2, 64'd3, 64'd5, 4'b0000, 1);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
